// File: rtl/sensor_switch_arbiter_if.sv
// rtl/sensor_switch_arbiter_if.sv - sensor inputs and switch-driver outputs of the arbiter
// master drives the raw sensors; slave is the arbiter itself.
interface sensor_switch_arbiter_if #(
    parameter int NCH = 3
);
    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [NCH-1:0] sensor;
    logic [NCH-1:0] switch;
    logic [IW-1:0]  grant_id;
    logic           busy;
    logic           timeout;
    logic [NCH-1:0] lockout;

    modport master (
        output sensor,
        input  switch,
        input  grant_id,
        input  busy,
        input  timeout,
        input  lockout
    );

    modport slave (
        input  sensor,
        output switch,
        output grant_id,
        output busy,
        output timeout,
        output lockout
    );
endinterface

// File: rtl/sensor_switch_arbiter.sv
// rtl/sensor_switch_arbiter.sv - round-robin single-switch arbiter with debounce and on/off timing
// At most one switch is on; grants last MIN_ON..MAX_ON cycles and are separated by a GAP.
module sensor_switch_arbiter #(
    parameter int NCH     = 3,
    parameter int DEB_CYC = 6,
    parameter int MIN_ON  = 10,
    parameter int MAX_ON  = 80,
    parameter int GAP     = 40,
    parameter int CW      = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    sensor_switch_arbiter_if.slave    bus_io
);
    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t          state_q;
    logic [NCH-1:0]  sync1_q;
    logic [NCH-1:0]  sync2_q;
    logic [CW-1:0]   deb_cnt_q [NCH];
    logic [CW-1:0]   deb_cnt_d [NCH];
    logic [NCH-1:0]  lockout_q;
    logic [NCH-1:0]  lockout_d;
    logic [NCH-1:0]  switch_q;
    logic [IW-1:0]   gid_q;
    logic [IW-1:0]   ptr_q;
    logic [CW-1:0]   on_cnt_q;
    logic [CW-1:0]   gap_cnt_q;
    logic            timeout_q;

    logic [NCH-1:0]  req;
    logic [IW-1:0]   pick;
    logic [IW-1:0]   ptr_next;
    logic            s_k;
    logic            max_hit;
    logic            release_now;
    logic            to_fire;

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            if (!sync2_q[i]) begin
                deb_cnt_d[i] = '0;
            end else if (deb_cnt_q[i] == CW'(DEB_CYC)) begin
                deb_cnt_d[i] = deb_cnt_q[i];
            end else begin
                deb_cnt_d[i] = deb_cnt_q[i] + CW'(1);
            end
            req[i] = (deb_cnt_q[i] == CW'(DEB_CYC)) && !lockout_q[i];
        end
    end

    // Scan offsets from the far end so the closest requester at/after ptr wins.
    always_comb begin
        pick = ptr_q;
        for (int j = NCH - 1; j >= 0; j--) begin
            if (req[(int'(ptr_q) + j) % NCH]) begin
                pick = IW'((int'(ptr_q) + j) % NCH);
            end
        end
    end

    always_comb begin
        s_k         = sync2_q[gid_q];
        max_hit     = (state_q == ST_GRANT) && (on_cnt_q == CW'(MAX_ON));
        release_now = (state_q == ST_GRANT) &&
                      (((on_cnt_q >= CW'(MIN_ON)) && !s_k) || max_hit);
        // A sensor that drops exactly at MAX_ON is a normal release, not a timeout.
        to_fire     = max_hit && s_k;
        ptr_next    = (gid_q == IW'(NCH - 1)) ? '0 : gid_q + IW'(1);
        lockout_d   = (lockout_q & sync2_q) | (to_fire ? (NCH'(1) << gid_q) : '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            lockout_q <= '0;
            for (int i = 0; i < NCH; i++) begin
                deb_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q   <= bus_io.sensor;
            sync2_q   <= sync1_q;
            lockout_q <= lockout_d;
            for (int i = 0; i < NCH; i++) begin
                deb_cnt_q[i] <= deb_cnt_d[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            switch_q  <= '0;
            gid_q     <= '0;
            ptr_q     <= '0;
            on_cnt_q  <= '0;
            gap_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= to_fire;
            case (state_q)
                ST_IDLE: begin
                    if (|req) begin
                        state_q  <= ST_GRANT;
                        switch_q <= NCH'(1) << pick;
                        gid_q    <= pick;
                        on_cnt_q <= CW'(1);
                    end
                end
                ST_GRANT: begin
                    if (release_now) begin
                        state_q   <= ST_GAP;
                        switch_q  <= '0;
                        ptr_q     <= ptr_next;
                        gap_cnt_q <= CW'(1);
                    end else begin
                        on_cnt_q <= on_cnt_q + CW'(1);
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_q == CW'(GAP)) begin
                        state_q <= ST_IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + CW'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus_io.switch   = switch_q;
    assign bus_io.grant_id = gid_q;
    assign bus_io.busy     = (state_q != ST_IDLE);
    assign bus_io.timeout  = timeout_q;
    assign bus_io.lockout  = lockout_q;
endmodule

// File: tb/tb_sensor_switch_arbiter.sv
// tb/tb_sensor_switch_arbiter.sv - directed vector bench for sensor_switch_arbiter
module tb_sensor_switch_arbiter;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    sensor_switch_arbiter_if #(.NCH(3)) bus_if ();

    sensor_switch_arbiter #(
        .NCH(3), .DEB_CYC(6), .MIN_ON(10), .MAX_ON(80), .GAP(40), .CW(8)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] sensor;
        int         ticks;
        logic [2:0] sw;
        logic       busy;
        logic [1:0] gid;
    } vec_t;

    vec_t vecs [10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            total++;
            if (!$onehot0(bus_if.switch)) begin
                bad++;
                $display("FAIL onehot0: got %b want one-hot-or-zero", bus_if.switch);
            end
        end
    end

    task automatic wait_idle(input string name, input int limit);
        int n;
        n = 0;
        while (bus_if.busy && n < limit) begin
            tick();
            n++;
        end
        check(name, 32'(bus_if.busy), 32'd0);
    endtask

    // Measures one grant: off cycles before it, its owner, length and end-of-grant flags.
    task automatic measure_grant(input int id, input int exp_len, input logic exp_to,
                                 input logic [2:0] exp_lock, input int exp_off);
        int off;
        int len;
        off = 2;
        while (bus_if.switch == 3'b000 && off < 400) begin
            tick();
            if (bus_if.switch == 3'b000) off++;
        end
        if (off >= 400) begin
            check("grant_start_bound", 32'(off), 32'd0);
            return;
        end
        if (exp_off >= 0) check("off_gap", 32'(off), 32'(exp_off));
        check("grant_switch", 32'(bus_if.switch), 32'(3'b001 << id));
        check("grant_id", 32'(bus_if.grant_id), 32'(id));
        len = 1;
        while (bus_if.switch != 3'b000 && len < 400) begin
            tick();
            if (bus_if.switch != 3'b000) len++;
        end
        check("grant_len", 32'(len), 32'(exp_len));
        check("grant_timeout", 32'(bus_if.timeout), 32'(exp_to));
        check("grant_lockout", 32'(bus_if.lockout), 32'(exp_lock));
        tick();
        check("timeout_pulse_end", 32'(bus_if.timeout), 32'd0);
    endtask

    initial begin
        int cnt;
        int n;
        logic to_seen;
        logic any_sw;

        total = 0;
        bad   = 0;

        vecs[0] = '{3'b001,  5, 3'b000, 1'b0, 2'd0};
        vecs[1] = '{3'b000, 10, 3'b000, 1'b0, 2'd0};
        vecs[2] = '{3'b010,  8, 3'b000, 1'b0, 2'd0};
        vecs[3] = '{3'b010,  1, 3'b010, 1'b1, 2'd1};
        vecs[4] = '{3'b010, 21, 3'b010, 1'b1, 2'd1};
        vecs[5] = '{3'b000,  2, 3'b010, 1'b1, 2'd1};
        vecs[6] = '{3'b000,  1, 3'b000, 1'b1, 2'd1};
        vecs[7] = '{3'b000, 39, 3'b000, 1'b1, 2'd1};
        vecs[8] = '{3'b000,  1, 3'b000, 1'b0, 2'd1};
        vecs[9] = '{3'b000,  5, 3'b000, 1'b0, 2'd1};

        rst = 1'b1;
        bus_if.sensor = 3'b000;
        repeat (3) @(posedge clk);
        #1;
        check("rst_switch", 32'(bus_if.switch), 32'd0);
        check("rst_gid", 32'(bus_if.grant_id), 32'd0);
        check("rst_busy", 32'(bus_if.busy), 32'd0);
        check("rst_timeout", 32'(bus_if.timeout), 32'd0);
        check("rst_lockout", 32'(bus_if.lockout), 32'd0);
        rst = 1'b0;

        // Short pulse on ch0 never debounces; ch1 grant starts 9 edges after its rise.
        for (int v = 0; v < 10; v++) begin
            bus_if.sensor = vecs[v].sensor;
            for (int t = 0; t < vecs[v].ticks; t++) tick();
            check($sformatf("vec%0d_switch", v), 32'(bus_if.switch), 32'(vecs[v].sw));
            check($sformatf("vec%0d_busy", v), 32'(bus_if.busy), 32'(vecs[v].busy));
            check($sformatf("vec%0d_gid", v), 32'(bus_if.grant_id), 32'(vecs[v].gid));
            check($sformatf("vec%0d_timeout", v), 32'(bus_if.timeout), 32'd0);
            check($sformatf("vec%0d_lockout", v), 32'(bus_if.lockout), 32'd0);
        end

        // Ch2 drops early: grant still lasts MIN_ON.
        bus_if.sensor = 3'b100;
        cnt = 0;
        to_seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus_if.switch == 3'b100) cnt++;
            to_seen |= bus_if.timeout;
        end
        bus_if.sensor = 3'b000;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (bus_if.switch == 3'b100) cnt++;
            to_seen |= bus_if.timeout;
        end
        check("minon_len", 32'(cnt), 32'd10);
        check("minon_timeout", 32'(to_seen), 32'd0);
        wait_idle("minon_idle", 100);

        // All held: round robin 0,1,2 with MAX_ON timeouts and accumulating lockout.
        bus_if.sensor = 3'b111;
        measure_grant(0, 80, 1'b1, 3'b001, -1);
        measure_grant(1, 80, 1'b1, 3'b011, 41);
        measure_grant(2, 80, 1'b1, 3'b111, 41);
        any_sw = 1'b0;
        for (int i = 0; i < 150; i++) begin
            tick();
            any_sw |= (bus_if.switch != 3'b000);
        end
        check("locked_no_grant", 32'(any_sw), 32'd0);
        check("locked_busy", 32'(bus_if.busy), 32'd0);
        check("locked_lockout", 32'(bus_if.lockout), 32'(3'b111));
        bus_if.sensor = 3'b000;
        tick();
        tick();
        check("lockout_hold", 32'(bus_if.lockout), 32'(3'b111));
        tick();
        check("lockout_clear", 32'(bus_if.lockout), 32'd0);

        // Ch0 re-granted after unlock; drops so that s is low exactly at on_cnt==MAX_ON.
        bus_if.sensor = 3'b001;
        n = 0;
        while (bus_if.switch == 3'b000 && n < 50) begin
            tick();
            n++;
        end
        check("regrant_switch", 32'(bus_if.switch), 32'(3'b001));
        cnt = 1;
        to_seen = 1'b0;
        for (int i = 0; i < 77; i++) begin
            tick();
            if (bus_if.switch == 3'b001) cnt++;
            to_seen |= bus_if.timeout;
        end
        bus_if.sensor = 3'b000;
        n = 0;
        while (bus_if.switch != 3'b000 && n < 50) begin
            tick();
            n++;
            if (bus_if.switch != 3'b000) cnt++;
            to_seen |= bus_if.timeout;
        end
        check("maxdrop_len", 32'(cnt), 32'd80);
        check("maxdrop_timeout", 32'(to_seen), 32'd0);
        check("maxdrop_lockout", 32'(bus_if.lockout), 32'd0);
        wait_idle("maxdrop_idle", 100);

        // Reset in the middle of a ch1 grant.
        bus_if.sensor = 3'b010;
        n = 0;
        while (bus_if.switch == 3'b000 && n < 50) begin
            tick();
            n++;
        end
        check("pre_rst_switch", 32'(bus_if.switch), 32'(3'b010));
        repeat (20) tick();
        #1;
        rst = 1'b1;
        #1;
        check("midrst_switch", 32'(bus_if.switch), 32'd0);
        check("midrst_lockout", 32'(bus_if.lockout), 32'd0);
        check("midrst_busy", 32'(bus_if.busy), 32'd0);
        check("midrst_timeout", 32'(bus_if.timeout), 32'd0);
        #1;
        rst = 1'b0;
        repeat (8) tick();
        check("post_rst_not_yet", 32'(bus_if.switch), 32'd0);
        tick();
        check("post_rst_regrant", 32'(bus_if.switch), 32'(3'b010));
        check("post_rst_gid", 32'(bus_if.grant_id), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end
endmodule
